// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: a core port and a loader/debug port share one
// single-cycle-write, one-cycle-latency-read memory under round-robin priority.
module dmem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic          memRead,
  output logic          memWrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writeData,
  input  logic [DW-1:0] ReadData
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        prio;
  logic        owner;
  logic        rd_pend0;
  logic        rd_pend1;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = '0;
    writeData = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || !prio)) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
          if (gnt0) begin
            memRead   = ~we0;
            memWrite  = we0;
            address   = addr0;
            writeData = wdata0;
          end else if (gnt1) begin
            memRead   = ~we1;
            memWrite  = we1;
            address   = addr1;
            writeData = wdata1;
          end
          if ((gnt0 && !we0) || (gnt1 && !we1)) begin
            state_nx = RD_WAIT;
          end
        end
        RD_WAIT: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Read return is a decode of registered state; reset masks it so an
  // aborted read never shows a return pulse.
  assign rd_pend0 = (state == RD_WAIT) && !owner;
  assign rd_pend1 = (state == RD_WAIT) && owner;
  assign rvalid0  = rd_pend0 && !reset;
  assign rvalid1  = rd_pend1 && !reset;
  assign rdata0   = rvalid0 ? ReadData : '0;
  assign rdata1   = rvalid1 ? ReadData : '0;
  assign stall0   = !reset && ((req0 && !gnt0) || rd_pend0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      state <= state_nx;
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end
      if (gnt0 && !we0) begin
        owner <= 1'b0;
      end else if (gnt1 && !we1) begin
        owner <= 1'b1;
      end
      if (gnt0 && (grant_cnt0 != 16'hFFFF)) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (gnt1 && (grant_cnt1 != 16'hFFFF)) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, hand sequences for the
// multi-cycle corners, and per-port read-data scoreboards fed from a memory model.
module tb_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall0, memRead, memWrite;
  logic [DW-1:0] rdata0, rdata1, writeData, read_data;
  logic [AW-1:0] address;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .ReadData(read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mem_init(input int i);
    if (i == 'h40) return 64'h0000_0000_DEAD_BEEF;
    return {32'hC0DE_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)};
  endfunction

  // Memory model: one-cycle read latency, writes land at the edge.
  logic          mem_load;
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else begin
      if (memRead) read_data <= mem[address[7:0]];
      if (memWrite) mem[address[7:0]] <= writeData;
    end
  end

  typedef struct {
    logic          rst, r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, mr, mw, st, v0, v1;
  } vec_t;

  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int checks = 0;
  int errors = 0;
  vec_t tbl [17];

  function automatic vec_t mk(input logic rst, r0, r1, w0, w1,
                              input logic [AW-1:0] a0, a1,
                              input logic [DW-1:0] d0, d1,
                              input logic g0, g1, mr, mw, st, v0, v1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mr = mr; v.mw = mw; v.st = st; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, e0, e1;
    @(negedge clk);
    reset = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    #2;
    ea = v.g0 ? v.a0 : (v.g1 ? v.a1 : '0);
    ed = v.g0 ? v.d0 : (v.g1 ? v.d1 : '0);
    check({tag, " gnt0"}, 64'(gnt0), 64'(v.g0));
    check({tag, " gnt1"}, 64'(gnt1), 64'(v.g1));
    check({tag, " memRead"}, 64'(memRead), 64'(v.mr));
    check({tag, " memWrite"}, 64'(memWrite), 64'(v.mw));
    check({tag, " address"}, address, ea);
    check({tag, " writeData"}, writeData, ed);
    check({tag, " stall0"}, 64'(stall0), 64'(v.st));
    check({tag, " rvalid0"}, 64'(rvalid0), 64'(v.v0));
    check({tag, " rvalid1"}, 64'(rvalid1), 64'(v.v1));
    e0 = '0;
    e1 = '0;
    if (rvalid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s rdata0: return with no read outstanding", tag);
      end else e0 = q0.pop_front();
    end
    if (rvalid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s rdata1: return with no read outstanding", tag);
      end else e1 = q1.pop_front();
    end
    check({tag, " rdata0"}, rdata0, e0);
    check({tag, " rdata1"}, rdata1, e1);
    if (!v.rst && v.g0) begin
      if (v.w0) exp_mem[v.a0[7:0]] = v.d0;
      else q0.push_back(exp_mem[v.a0[7:0]]);
    end
    if (!v.rst && v.g1) begin
      if (v.w1) exp_mem[v.a1[7:0]] = v.d1;
      else q1.push_back(exp_mem[v.a1[7:0]]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    logic rd_wait, need_new, rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    reset = 1'b1; mem_load = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem_init(i);
    idle = mk(0,0,0,0,0, 'h0,'h0, 'h0,'h0, 0,0,0,0,0,0,0);

    // reset holds combinational outputs low even with both ports requesting
    apply(mk(1,1,1,0,0, 'h10,'h20, 'h0,'h0, 0,0,0,0,0,0,0), "rst0");
    apply(mk(1,1,1,0,0, 'h10,'h20, 'h0,'h0, 0,0,0,0,0,0,0), "rst1");
    mem_load = 1'b0;
    check("rst grant_cnt0", 64'(dut.grant_cnt0), 64'h0);
    check("rst grant_cnt1", 64'(dut.grant_cnt1), 64'h0);

    //            rst r0 r1 w0 w1  a0    a1     d0       d1      g0 g1 mr mw st v0 v1
    tbl[0]  = mk(0, 1, 1, 0, 0, 'h10, 'h20, 'h0,    'h0,    1, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 'h10, 'h20, 'h0,    'h0,    0, 0, 0, 0, 1, 1, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 'h10, 'h20, 'h0,    'h0,    0, 1, 1, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 'h10, 'h20, 'h0,    'h0,    0, 0, 0, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 'h0,  'h0,  'h0,    'h0,    0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 1, 1, 'h30, 'h38, 'h1111, 'h2222, 1, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 1, 'h30, 'h38, 'h1111, 'h2222, 0, 1, 0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 1, 1, 1, 'h30, 'h38, 'h1111, 'h2222, 1, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 1, 1, 'h30, 'h38, 'h1111, 'h2222, 0, 1, 0, 1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 'h0,  'h38, 'h0,    'h0,    0, 1, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 'h0,  'h0,  'h0,    'h0,    0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 'h30, 'h0,  'h0,    'h0,    1, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 'h0,  'h0,  'h0,    'h0,    0, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 1, 'h0,  'h50, 'h0,    'h3333, 0, 1, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 1, 1, 0, 'h58, 'h50, 'h4444, 'h0,    1, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 'h0,  'h50, 'h0,    'h0,    0, 1, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 'h0,  'h0,  'h0,    'h0,    0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // port-1 read of 0x40 with a port-0 write arriving during its return
    apply(mk(0,0,1,0,0, 'h0,'h40, 'h0,'h0,  0,1,1,0,0,0,0), "rd1_grant");
    apply(mk(0,1,0,1,0, 'h48,'h0, 'h77,'h0, 0,0,0,0,1,0,1), "rd1_return");
    apply(mk(0,1,0,1,0, 'h48,'h0, 'h77,'h0, 1,0,0,1,0,0,0), "wr0_after");

    // reset pulse inside a port-0 read aborts it and restores port-0 priority
    apply(mk(0,1,0,0,0, 'h10,'h0, 'h0,'h0, 1,0,1,0,0,0,0), "abort_grant");
    void'(q0.pop_back());
    apply(mk(1,0,0,0,0, 'h0,'h0, 'h0,'h0, 0,0,0,0,0,0,0), "abort_rst");
    apply(idle, "abort_idle");
    apply(mk(0,1,1,1,1, 'h60,'h68, 'h5,'h6, 1,0,0,1,0,0,0), "abort_next0");
    apply(mk(0,1,1,1,1, 'h60,'h68, 'h5,'h6, 0,1,0,1,1,0,0), "abort_next1");

    // grant counter saturation
    apply(idle, "sat_idle");
    force dut.grant_cnt0 = 16'hFFFE;
    #1;
    release dut.grant_cnt0;
    for (int k = 0; k < 3; k++) begin
      apply(mk(0,1,0,1,0, 'h70,'h0, 64'(k),'h0, 1,0,0,1,0,0,0), $sformatf("sat_wr%0d", k));
      check($sformatf("sat_cnt%0d", k), 64'(dut.grant_cnt0), (k == 0) ? 64'hFFFE : 64'hFFFF);
    end
    apply(idle, "sat_end");
    check("sat_cnt_hold", 64'(dut.grant_cnt0), 64'hFFFF);

    // port 0 alone with random traffic: stall only while its read returns
    rd_wait = 1'b0;
    need_new = 1'b1;
    rw = 1'b0; ra = '0; rd = '0;
    for (int k = 0; k < 10; k++) begin
      if (need_new) begin
        rw = 1'($urandom_range(0, 1));
        ra = AW'($urandom_range(0, 31) * 8);
        rd = {$urandom, $urandom};
      end
      if (!rd_wait) begin
        apply(mk(0,1,0,rw,0, ra,'h0, rd,'h0, 1,0,~rw,rw,0,0,0), $sformatf("solo%0d", k));
        rd_wait = ~rw;
        need_new = 1'b1;
      end else begin
        apply(mk(0,1,0,rw,0, ra,'h0, rd,'h0, 0,0,0,0,1,1,0), $sformatf("solo%0d", k));
        rd_wait = 1'b0;
        need_new = 1'b0;
      end
    end
    apply(mk(0,0,0,0,0, 'h0,'h0, 'h0,'h0, 0,0,0,0,rd_wait,rd_wait,0), "solo_drain");
    check("sb_empty", 64'(q0.size() + q1.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
